// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM states and default operand width.
package alu_pkg;
  localparam int MUL_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_t;
endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/product handshake bundle for the shift-and-add multiplier.
interface shift_add_multiplier_if
  import alu_pkg::*;
#(
  parameter int W = MUL_W_DEFAULT
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/shift_add_multiplier_adder.sv
// Parameterised W-bit ripple-carry adder; cout_o is the MSB carry.
module FullAdder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  logic [W:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[W];
endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative radix-2 shift-and-add multiplier, W accumulate steps per op.
// Optional signed support (magnitude multiply + final negate) under MUL_SIGNED_EN.
module shift_add_multiplier
  import alu_pkg::*;
#(
  parameter int W = MUL_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_add_multiplier_if.slave bus
);
  localparam int CW = $clog2(W) + 1;

  mul_state_t   state_q, state_d;
  logic [W-1:0] mcand_q, mcand_d;
  logic [W-1:0] acc_hi_q, acc_hi_d;
  logic [W-1:0] acc_lo_q, acc_lo_d;
  logic [CW-1:0] count_q, count_d;

  logic [W-1:0] op_a, op_b;
  logic [W-1:0] addend, sum;
  logic         carry;

`ifdef MUL_SIGNED_EN
  logic sgn_q, sgn_d;
  logic neg_q, neg_d;
  logic neg_a, neg_b;

  // The magnitude of the most negative value wraps to 2^(W-1), which is
  // exactly its unsigned magnitude, so no extra width is needed.
  assign neg_a = bus.in_signed & bus.in_a[W-1];
  assign neg_b = bus.in_signed & bus.in_b[W-1];
  assign op_a  = neg_a ? (~bus.in_a + W'(1)) : bus.in_a;
  assign op_b  = neg_b ? (~bus.in_b + W'(1)) : bus.in_b;
`else
  assign op_a = bus.in_a;
  assign op_b = bus.in_b;
`endif

  assign addend = acc_lo_q[0] ? mcand_q : '0;

  FullAdder #(.W(W)) u_add (
    .a_i    (acc_hi_q),
    .b_i    (addend),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (carry)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    count_d  = count_q;
`ifdef MUL_SIGNED_EN
    sgn_d    = sgn_q;
    neg_d    = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d  = op_a;
          acc_hi_d = '0;
          acc_lo_d = op_b;
          count_d  = '0;
`ifdef MUL_SIGNED_EN
          sgn_d    = bus.in_signed;
          neg_d    = neg_a ^ neg_b;
`endif
          state_d  = RUN;
        end
      end
      RUN: begin
        {acc_hi_d, acc_lo_d} = {carry, sum, acc_lo_q[W-1:1]};
        count_d = count_q + CW'(1);
        if (count_q == CW'(W - 1)) begin
`ifdef MUL_SIGNED_EN
          state_d = sgn_q ? FIX : DONE;
`else
          state_d = DONE;
`endif
        end
      end
      FIX: begin
`ifdef MUL_SIGNED_EN
        if (neg_q)
          {acc_hi_d, acc_lo_d} = ~{acc_hi_q, acc_lo_q} + {{(2*W-1){1'b0}}, 1'b1};
        state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      count_q  <= '0;
`ifdef MUL_SIGNED_EN
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      count_q  <= count_d;
`ifdef MUL_SIGNED_EN
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.product   = {acc_hi_q, acc_lo_q};
endmodule
